// File: rtl/matrix_tile_accum_pkg.sv
// Shared types and constants for the tiled matrix-vector engine.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    // Products (S1), row sums (S2), accumulate (S3).
    localparam int PIPE_LAT = 3;

    // Narrowest accumulator that holds a full N-term dot product without loss.
    function automatic int min_acc_w(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_tile_accum_if.sv
// Beat/result handshake bundle between a producer and the tile engine.
interface matrix_tile_accum_if #(
    parameter int M     = 16,
    parameter int N     = 16,
    parameter int DW    = 16,
    parameter int ACC_W = 40,
    parameter int BCW   = 16
);
    logic [M*N*DW-1:0]  matrix_in;
    logic [N*DW-1:0]    vec_in;
    logic               in_valid;
    logic               in_last;
    logic               relu_en;
    logic               in_ready;
    logic [M*ACC_W-1:0] vec_out;
    logic [BCW-1:0]     out_beats;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output matrix_in, vec_in, in_valid, in_last, relu_en, out_ready,
        input  in_ready, vec_out, out_beats, out_valid
    );

    modport slave (
        input  matrix_in, vec_in, in_valid, in_last, relu_en, out_ready,
        output in_ready, vec_out, out_beats, out_valid
    );
endinterface

// File: rtl/matrix_tile_accum_mac_row.sv
// One result row: N signed multipliers (S1) feeding an adder tree (S2).
module mac_row #(
    parameter int N     = 16,
    parameter int DW    = 16,
    parameter int ACC_W = 40
) (
    input  logic                    clk,
    input  logic                    en1,
    input  logic                    en2,
    input  logic [N*DW-1:0]         row,
    input  logic [N*DW-1:0]         vec,
    output logic signed [ACC_W-1:0] sum
);
    logic signed [2*DW-1:0] prod_q [N];
    logic signed [ACC_W-1:0] tree;

    for (genvar c = 0; c < N; c++) begin : g_col
        logic signed [2*DW-1:0] a, b;
        assign a = (2*DW)'($signed(row[c*DW +: DW]));
        assign b = (2*DW)'($signed(vec[c*DW +: DW]));

        // S1: capture this column's product when a beat is accepted
        always_ff @(posedge clk) begin
            if (en1) prod_q[c] <= a * b;
        end
    end

    // Sign-extend every product to accumulator width and reduce
    always_comb begin
        tree = '0;
        for (int c = 0; c < N; c++) tree = tree + ACC_W'(prod_q[c]);
    end

    // S2: register the row sum while the S1 slot holds a live beat
    always_ff @(posedge clk) begin
        if (en2) sum <= tree;
    end

endmodule

// File: rtl/matrix_tile_accum.sv
// Tiled y = W*x engine: per-row MAC pipeline, cross-beat accumulation,
// optional ReLU and a single-result output handshake.
module matrix_tile_accum import mm_pkg::*; #(
    parameter int M     = 16,
    parameter int N     = 16,
    parameter int DW    = 16,
    parameter int ACC_W = 40,
    parameter int BCW   = 16
) (
    input logic                clk,
    input logic                rst,
    matrix_tile_accum_if.slave bus
);
    if (ACC_W < min_acc_w(DW, N)) begin : g_chk_acc
        $error("matrix_tile_accum: ACC_W narrower than 2*DW+clog2(N)");
    end
    if (N < 2 || (N & (N - 1)) != 0) begin : g_chk_n
        $error("matrix_tile_accum: N must be a power of two >= 2");
    end

    state_t                      state;
    logic                        in_ready_q;
    logic                        out_valid_q;
    logic [M-1:0][ACC_W-1:0]     acc;
    logic [M-1:0][ACC_W-1:0]     relu_vec;
    logic [M-1:0][ACC_W-1:0]     vec_out_q;
    logic [M-1:0][ACC_W-1:0]     row_sum;
    logic [BCW-1:0]              beat_cnt;
    logic [BCW-1:0]              out_beats_q;
    logic                        relu_q;
    logic                        in_fire;
    logic [PIPE_LAT:1]           vld_pipe;
    logic [PIPE_LAT-1:1]         first_pipe;

    // Reset masks in_ready combinationally so no beat slips in while held.
    assign bus.in_ready  = in_ready_q && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.vec_out   = vec_out_q;
    assign bus.out_beats = out_beats_q;
    assign in_fire       = bus.in_valid && bus.in_ready;

    for (genvar r = 0; r < M; r++) begin : g_row
        mac_row #(.N(N), .DW(DW), .ACC_W(ACC_W)) u_mac_row (
            .clk (clk),
            .en1 (in_fire),
            .en2 (vld_pipe[1]),
            .row (bus.matrix_in[r*N*DW +: N*DW]),
            .vec (bus.vec_in),
            .sum (row_sum[r])
        );
    end

    // Valid and first-beat flags travel alongside the datapath stages
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            first_pipe <= '0;
        end else begin
            vld_pipe   <= {vld_pipe[PIPE_LAT-1:1], in_fire};
            first_pipe <= {first_pipe[PIPE_LAT-2:1], in_fire && state == IDLE};
        end
    end

    // S3: first beat of a job loads, later beats add (wrapping)
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (vld_pipe[PIPE_LAT-1]) begin
            for (int r = 0; r < M; r++)
                acc[r] <= first_pipe[PIPE_LAT-1] ? row_sum[r] : acc[r] + row_sum[r];
        end
    end

    // ReLU on the final sums, using the flag latched at the job's first beat
    always_comb begin
        relu_vec = '0;
        for (int r = 0; r < M; r++)
            relu_vec[r] = (relu_q && acc[r][ACC_W-1]) ? '0 : acc[r];
    end

    // Job FSM with registered handshake outputs, beat count and result
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            vec_out_q   <= '0;
            out_beats_q <= '0;
            beat_cnt    <= '0;
            relu_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_fire) begin
                    beat_cnt <= BCW'(1);
                    relu_q   <= bus.relu_en;
                    if (bus.in_last) begin
                        state      <= DRAIN;
                        in_ready_q <= 1'b0;
                    end else begin
                        state <= ACCUM;
                    end
                end
                ACCUM: if (in_fire) begin
                    if (beat_cnt != '1) beat_cnt <= beat_cnt + BCW'(1);
                    if (bus.in_last) begin
                        state      <= DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
                // Leave once the final beat has been folded into acc.
                DRAIN: if (vld_pipe[PIPE_LAT] && vld_pipe[PIPE_LAT-1:1] == '0) begin
                    state       <= OUTPUT;
                    out_valid_q <= 1'b1;
                    vec_out_q   <= relu_vec;
                    out_beats_q <= beat_cnt;
                end
                OUTPUT: if (bus.out_ready) begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_tile_accum.sv
// Bench for matrix_tile_accum: directed jobs plus random jobs, all checked
// every cycle against a job-level arithmetic model.
module tb_matrix_tile_accum;
    localparam int M = 16, N = 16, DW = 16, ACC_W = 40, BCW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    matrix_tile_accum_if #(.M(M), .N(N), .DW(DW), .ACC_W(ACC_W), .BCW(BCW)) bus();

    matrix_tile_accum #(.M(M), .N(N), .DW(DW), .ACC_W(ACC_W), .BCW(BCW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // model state: job accumulators, beat count, relu flag, busy window
    logic [ACC_W-1:0] macc [M];
    int  mbeats   = 0;
    bit  mrelu    = 0;
    bit  busy     = 0;
    bit  in_job   = 0;
    int  done_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [ACC_W-1:0] exp_row(input int r);
        return (mrelu && macc[r][ACC_W-1]) ? '0 : macc[r];
    endfunction

    // compare DUT with model, then advance the model to the coming edge
    always @(negedge clk) begin : p_model
        bit     exp_rdy, exp_ov;
        longint dot, a, b;
        exp_rdy = !rst && !busy;
        exp_ov  = busy && (cyc >= done_cyc);
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
        if (exp_ov) begin
            for (int r = 0; r < M; r++)
                chk($sformatf("vec_out[%0d]", r), 64'(bus.vec_out[r*ACC_W +: ACC_W]), 64'(exp_row(r)));
            chk("out_beats", 64'(bus.out_beats), 64'((mbeats > 65535) ? 65535 : mbeats));
        end
        if (rst) begin
            busy = 0; in_job = 0; mbeats = 0; mrelu = 0;
            for (int r = 0; r < M; r++) macc[r] = '0;
        end else if (exp_ov && bus.out_ready) begin
            busy = 0; in_job = 0;
        end else if (exp_rdy && bus.in_valid) begin
            for (int r = 0; r < M; r++) begin
                dot = 0;
                for (int c = 0; c < N; c++) begin
                    a = longint'($signed(bus.matrix_in[(r*N+c)*DW +: DW]));
                    b = longint'($signed(bus.vec_in[c*DW +: DW]));
                    dot = dot + a * b;
                end
                macc[r] = in_job ? macc[r] + ACC_W'(dot) : ACC_W'(dot);
            end
            if (!in_job) begin
                in_job = 1; mrelu = bus.relu_en; mbeats = 0;
            end
            mbeats++;
            if (bus.in_last) begin
                busy = 1; done_cyc = cyc + 4;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_w_const(input int v);
        for (int i = 0; i < M*N; i++) bus.matrix_in[i*DW +: DW] = DW'(v);
    endtask
    task automatic set_x_const(input int v);
        for (int i = 0; i < N; i++) bus.vec_in[i*DW +: DW] = DW'(v);
    endtask
    task automatic set_w_ident();
        bus.matrix_in = '0;
        for (int r = 0; r < M; r++) bus.matrix_in[(r*N+r)*DW +: DW] = DW'(1);
    endtask
    task automatic set_x_ramp();
        for (int i = 0; i < N; i++) bus.vec_in[i*DW +: DW] = DW'(i + 1);
    endtask
    task automatic set_rand();
        for (int i = 0; i < M*N; i++) bus.matrix_in[i*DW +: DW] = DW'($urandom);
        for (int i = 0; i < N; i++) bus.vec_in[i*DW +: DW] = DW'($urandom);
    endtask

    // offer one beat until accepted (bounded), then idle `gap` cycles
    task automatic send_beat(input bit last, input bit relu, input int gap);
        bit ok = 0;
        bus.in_valid = 1; bus.in_last = last; bus.relu_en = relu;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk); ok = bus.in_ready;
            step();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL beat_accept: got no in_ready expected accept within 50 cycles"); end
        bus.in_valid = 0; bus.in_last = 0;
        repeat (gap) step();
    endtask

    // return at a negedge with out_valid high (bounded)
    task automatic wait_valid();
        bit ok = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk); ok = bus.out_valid;
            if (!ok) step();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL result_wait: got out_valid=0 expected 1 within 40 cycles"); end
    endtask

    task automatic release_result(input int hold);
        step();
        repeat (hold) step();
        bus.out_ready = 1;
        step();
        bus.out_ready = 0;
    endtask

    task automatic chk_rows(input string name, input logic [ACC_W-1:0] v);
        for (int r = 0; r < M; r++) chk(name, 64'(bus.vec_out[r*ACC_W +: ACC_W]), 64'(v));
    endtask

    initial begin
        int acc_cyc;
        bus.matrix_in = '0; bus.vec_in = '0; bus.in_valid = 0; bus.in_last = 0;
        bus.relu_en = 0; bus.out_ready = 0;
        repeat (3) step();
        chk("rst_vec_out", 64'(bus.vec_out[ACC_W-1:0]), 64'd0);
        chk("rst_out_beats", 64'(bus.out_beats), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        step();

        // identity W, ramp x, single beat
        set_w_ident(); set_x_ramp();
        send_beat(1, 0, 0);
        acc_cyc = cyc;
        chk("drain_in_ready", 64'(bus.in_ready), 64'd0);
        wait_valid();
        chk("latency", 64'(cyc - acc_cyc), 64'd3);
        for (int r = 0; r < M; r++) chk("ident_row", 64'(bus.vec_out[r*ACC_W +: ACC_W]), 64'(r + 1));
        chk("ident_beats", 64'(bus.out_beats), 64'd1);
        release_result(0);

        // 3 beats back-to-back, then with 2-cycle gaps
        for (int g = 0; g <= 2; g += 2) begin
            set_w_const(1); set_x_const(2);
            send_beat(0, 0, g); send_beat(0, 0, g); send_beat(1, 0, 0);
            wait_valid();
            chk_rows("ones_x2_row", ACC_W'(96));
            chk("ones_x2_beats", 64'(bus.out_beats), 64'd3);
            release_result(1);
        end

        // negative result with and without ReLU
        set_w_const(-1); set_x_const(3);
        send_beat(1, 0, 0); wait_valid(); chk_rows("neg_row", ACC_W'(-48)); release_result(0);
        send_beat(1, 1, 0); wait_valid(); chk_rows("relu_row", ACC_W'(0)); release_result(0);
        send_beat(0, 0, 0); send_beat(1, 1, 0);
        wait_valid(); chk_rows("relu_late_row", ACC_W'(-96)); release_result(0);

        // backpressure with a next beat already waiting
        set_w_const(1); set_x_const(1);
        send_beat(1, 0, 0);
        wait_valid();
        step();
        bus.in_valid = 1; bus.in_last = 1; bus.relu_en = 0;
        repeat (10) step();
        chk("bp_rows_held", 64'(bus.vec_out[ACC_W-1:0]), 64'd16);
        bus.out_ready = 1;
        step();
        bus.out_ready = 0;
        chk("hs_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 0; bus.in_last = 0;
        chk("next_accepted", 64'(bus.in_ready), 64'd0);
        wait_valid(); chk_rows("bp_next_row", ACC_W'(16)); release_result(0);

        // reset while draining discards the job
        set_w_const(5); set_x_const(7);
        send_beat(1, 0, 0);
        rst = 1; step(); rst = 0;
        repeat (6) step();
        chk("rst_drain_no_valid", 64'(bus.out_valid), 64'd0);
        set_w_const(1); set_x_const(1);
        send_beat(1, 0, 0); wait_valid(); chk_rows("after_rst_row", ACC_W'(16)); release_result(0);

        // most negative operands, 4 beats: 2^36 exactly
        set_w_const(-32768); set_x_const(-32768);
        send_beat(0, 0, 0); send_beat(0, 0, 0); send_beat(0, 0, 0); send_beat(1, 0, 0);
        wait_valid(); chk_rows("extreme_row", ACC_W'(64'h10_0000_0000));
        chk("extreme_beats", 64'(bus.out_beats), 64'd4);
        release_result(0);

        // random jobs against the model
        for (int j = 0; j < 25; j++) begin
            int nb;
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                set_rand();
                send_beat(b == nb - 1, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            end
            wait_valid();
            release_result($urandom_range(0, 3));
        end

        repeat (4) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
